// File: rtl/bank_command_queue_b.sv
// Per-bank command queue: buffers PRE/ACT/CAS bundles in a FIFO and issues them
// one command at a time, in PRE -> ACT -> CAS order, over a valid/ready handshake.
module bank_command_queue_b #(
  parameter int CH_WIDTH       = 1,
  parameter int RNK_WIDTH      = 1,
  parameter int BG_WIDTH       = 1,
  parameter int BNK_WIDTH      = 2,
  parameter int ROW_WIDTH      = 18,
  parameter int COL_WIDTH      = 10,
  parameter int PTR_WIDTH      = 6,
  parameter int CMD_TYPE_WIDTH = 3,
  parameter int DEPTH          = 4,
  parameter int TCQ            = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CH_WIDTH-1:0]       i_channel,
  input  logic [RNK_WIDTH-1:0]      i_rank,
  input  logic [BG_WIDTH-1:0]       i_group,
  input  logic [BNK_WIDTH-1:0]      i_bank,
  input  logic [ROW_WIDTH-1:0]      i_row,
  input  logic [COL_WIDTH-1:0]      i_column,
  input  logic [PTR_WIDTH-1:0]      i_ptr,
  input  logic                      pre_bundle_valid,
  input  logic [CMD_TYPE_WIDTH-1:0] pre_bundle_cmd,
  input  logic                      act_bundle_valid,
  input  logic [CMD_TYPE_WIDTH-1:0] act_bundle_cmd,
  input  logic                      cas_bundle_valid,
  input  logic [CMD_TYPE_WIDTH-1:0] cas_bundle_cmd,
  output logic                      stall,
  output logic                      overflow_err,
  input  logic                      hold_issue,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [1:0]                cmd_class,
  output logic [CMD_TYPE_WIDTH-1:0] cmd_type,
  output logic [CH_WIDTH-1:0]       cmd_channel,
  output logic [RNK_WIDTH-1:0]      cmd_rank,
  output logic [BG_WIDTH-1:0]       cmd_group,
  output logic [BNK_WIDTH-1:0]      cmd_bank,
  output logic [ROW_WIDTH-1:0]      cmd_row,
  output logic [COL_WIDTH-1:0]      cmd_column,
  output logic [PTR_WIDTH-1:0]      cmd_ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // TCQ only documents the reference clock-to-q; it is range-checked here.
  if (DEPTH < 2 || TCQ < 0) begin : g_param_check
    $error("bank_command_queue_b: DEPTH must be >= 2 and TCQ >= 0");
  end

  typedef struct packed {
    logic [CH_WIDTH-1:0]       channel;
    logic [RNK_WIDTH-1:0]      rank;
    logic [BG_WIDTH-1:0]       group;
    logic [BNK_WIDTH-1:0]      bank;
    logic [ROW_WIDTH-1:0]      row;
    logic [COL_WIDTH-1:0]      column;
    logic [PTR_WIDTH-1:0]      ptr;
    logic                      pre_v;
    logic                      act_v;
    logic                      cas_v;
    logic [CMD_TYPE_WIDTH-1:0] pre_cmd;
    logic [CMD_TYPE_WIDTH-1:0] act_cmd;
    logic [CMD_TYPE_WIDTH-1:0] cas_cmd;
  } entry_t;

  typedef enum logic [1:0] {
    PH_PRE  = 2'd0,
    PH_ACT  = 2'd1,
    PH_CAS  = 2'd2,
    PH_IDLE = 2'd3
  } phase_t;

  entry_t          mem [DEPTH];
  entry_t          in_e;
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr, rd_inc, wr_inc;
  logic [CW-1:0]   count;
  phase_t          phase, phase_nx;
  logic            any_in, push, fire, pop, active;

  function automatic phase_t first_phase(input entry_t e);
    if (e.pre_v)      return PH_PRE;
    else if (e.act_v) return PH_ACT;
    else if (e.cas_v) return PH_CAS;
    else              return PH_IDLE;
  endfunction

  always_comb begin
    in_e = '{channel: i_channel, rank: i_rank, group: i_group, bank: i_bank,
             row: i_row, column: i_column, ptr: i_ptr,
             pre_v: pre_bundle_valid, act_v: act_bundle_valid, cas_v: cas_bundle_valid,
             pre_cmd: pre_bundle_cmd, act_cmd: act_bundle_cmd, cas_cmd: cas_bundle_cmd};
  end

  assign head   = mem[rd_ptr];
  assign rd_inc = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  assign wr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign stall  = (count == FULL);
  assign any_in = pre_bundle_valid | act_bundle_valid | cas_bundle_valid;
  assign push   = any_in & ~stall;
  assign active = (phase != PH_IDLE);
  assign cmd_valid = active & ~hold_issue;
  assign fire   = cmd_valid & cmd_ready;
  assign pop    = fire & ~((phase == PH_PRE && (head.act_v || head.cas_v)) ||
                           (phase == PH_ACT && head.cas_v));

  // When the head retires and it was the only entry, a bundle arriving in the
  // same cycle becomes the new head directly, which avoids a bubble.
  always_comb begin
    phase_nx = phase;
    if (phase == PH_IDLE) begin
      if (count != '0)  phase_nx = first_phase(head);
      else if (push)    phase_nx = first_phase(in_e);
    end else if (fire) begin
      if (phase == PH_PRE && head.act_v)      phase_nx = PH_ACT;
      else if (phase != PH_CAS && head.cas_v) phase_nx = PH_CAS;
      else if (count > CW'(1))                phase_nx = first_phase(mem[rd_inc]);
      else if (push)                          phase_nx = first_phase(in_e);
      else                                    phase_nx = PH_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      phase        <= PH_IDLE;
      overflow_err <= 1'b0;
    end else begin
      phase <= phase_nx;
      if (push) wr_ptr <= wr_inc;
      if (pop)  rd_ptr <= rd_inc;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (any_in && stall) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_e;
  end

  always_comb begin
    cmd_type = '0;
    case (phase)
      PH_PRE:  cmd_type = head.pre_cmd;
      PH_ACT:  cmd_type = head.act_cmd;
      PH_CAS:  cmd_type = head.cas_cmd;
      default: cmd_type = '0;
    endcase
  end

  assign cmd_class   = active ? 2'(phase)    : 2'd0;
  assign cmd_channel = active ? head.channel : '0;
  assign cmd_rank    = active ? head.rank    : '0;
  assign cmd_group   = active ? head.group   : '0;
  assign cmd_bank    = active ? head.bank    : '0;
  assign cmd_row     = active ? head.row     : '0;
  assign cmd_column  = active ? head.column  : '0;
  assign cmd_ptr     = active ? head.ptr     : '0;

endmodule

// File: tb/tb_bank_command_queue_b.sv
// Directed bench for bank_command_queue_b; issued commands are checked against a
// scoreboard queue filled when bundles are driven.
module tb_bank_command_queue_b;

  localparam logic [2:0] C_PRE = 3'd2;
  localparam logic [2:0] C_ACT = 3'd3;
  localparam logic [2:0] C_RD  = 3'd5;
  localparam logic [2:0] C_WR  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  i_channel = '0, i_rank = '0, i_group = '0;
  logic [1:0]  i_bank = '0;
  logic [17:0] i_row = '0;
  logic [9:0]  i_column = '0;
  logic [5:0]  i_ptr = '0;
  logic        pre_bundle_valid = 1'b0, act_bundle_valid = 1'b0, cas_bundle_valid = 1'b0;
  logic [2:0]  pre_bundle_cmd = '0, act_bundle_cmd = '0, cas_bundle_cmd = '0;
  logic        stall, overflow_err;
  logic        hold_issue = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_class;
  logic [2:0]  cmd_type;
  logic [0:0]  cmd_channel, cmd_rank, cmd_group;
  logic [1:0]  cmd_bank;
  logic [17:0] cmd_row;
  logic [9:0]  cmd_column;
  logic [5:0]  cmd_ptr;

  always #5 clk = ~clk;

  bank_command_queue_b #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_channel(i_channel), .i_rank(i_rank), .i_group(i_group), .i_bank(i_bank),
    .i_row(i_row), .i_column(i_column), .i_ptr(i_ptr),
    .pre_bundle_valid(pre_bundle_valid), .pre_bundle_cmd(pre_bundle_cmd),
    .act_bundle_valid(act_bundle_valid), .act_bundle_cmd(act_bundle_cmd),
    .cas_bundle_valid(cas_bundle_valid), .cas_bundle_cmd(cas_bundle_cmd),
    .stall(stall), .overflow_err(overflow_err), .hold_issue(hold_issue),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_class(cmd_class), .cmd_type(cmd_type),
    .cmd_channel(cmd_channel), .cmd_rank(cmd_rank), .cmd_group(cmd_group), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_column(cmd_column), .cmd_ptr(cmd_ptr)
  );

  typedef logic [43:0] obs_t;
  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t mk(input logic [1:0] c, input logic [2:0] t, input logic [1:0] bk,
                              input logic [17:0] row, input logic [9:0] col, input logic [5:0] p);
    // channel/rank/group are derived from row/ptr so every field varies per bundle
    return {c, t, row[0], row[1], p[0], bk, row, col, p};
  endfunction

  function automatic obs_t obs_cur();
    return {cmd_class, cmd_type, cmd_channel, cmd_rank, cmd_group, cmd_bank, cmd_row, cmd_column, cmd_ptr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge: any handshake seen here completes at the next posedge.
  task automatic mon();
    obs_t e;
    if (cmd_valid && cmd_ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_issue: observed %0h expected no command", obs_cur());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue", 64'(obs_cur()), 64'(e));
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic fin();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  task automatic set_bundle(input logic p, input logic a, input logic c, input logic [2:0] ct,
                            input logic [1:0] bk, input logic [17:0] row, input logic [9:0] col,
                            input logic [5:0] ptr, input logic accept);
    pre_bundle_valid = p; act_bundle_valid = a; cas_bundle_valid = c;
    pre_bundle_cmd = C_PRE; act_bundle_cmd = C_ACT; cas_bundle_cmd = ct;
    i_bank = bk; i_row = row; i_column = col; i_ptr = ptr;
    i_channel = row[0]; i_rank = row[1]; i_group = ptr[0];
    if (accept) begin
      if (p) sb.push_back(mk(2'd0, C_PRE, bk, row, col, ptr));
      if (a) sb.push_back(mk(2'd1, C_ACT, bk, row, col, ptr));
      if (c) sb.push_back(mk(2'd2, ct,    bk, row, col, ptr));
    end
  endtask

  task automatic clr_bundle();
    pre_bundle_valid = 1'b0; act_bundle_valid = 1'b0; cas_bundle_valid = 1'b0;
  endtask

  initial begin
    obs_t e;
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(cmd_valid), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_ovf", 64'(overflow_err), 64'(0));
    check("rst_fields", 64'(obs_cur()), 64'(0));
    rst_n = 1'b1;
    cyc();

    // full bundle, ready held high
    cmd_ready = 1'b1;
    set_bundle(1, 1, 1, C_RD, 2'd2, 18'h155, 10'h20, 6'd5, 1);
    half();
    check("t2_no_comb_path", 64'(cmd_valid), 64'(0));
    fin();
    clr_bundle();
    for (int i = 0; i < 3; i++) begin
      half();
      check("t2_valid", 64'(cmd_valid), 64'(1));
      check("t2_class", 64'(cmd_class), 64'(i));
      check("t2_row", 64'(cmd_row), 64'(18'h155));
      check("t2_ptr", 64'(cmd_ptr), 64'(5));
      fin();
    end
    half();
    check("t2_idle", 64'(cmd_valid), 64'(0));
    check("t2_sb_empty", 64'(sb.size()), 64'(0));
    fin();

    // CAS-only then ACT+CAS, back to back
    set_bundle(0, 0, 1, C_WR, 2'd1, 18'h0003A, 10'h011, 6'd9, 1);
    cyc();
    set_bundle(0, 1, 1, C_RD, 2'd3, 18'h20001, 10'h3FF, 6'h3F, 1);
    half();
    check("t3_v0", 64'(cmd_valid), 64'(1));
    check("t3_c0", 64'(cmd_class), 64'(2));
    fin();
    clr_bundle();
    half();
    check("t3_v1", 64'(cmd_valid), 64'(1));
    check("t3_c1", 64'(cmd_class), 64'(1));
    fin();
    half();
    check("t3_v2", 64'(cmd_valid), 64'(1));
    check("t3_c2", 64'(cmd_class), 64'(2));
    fin();
    half();
    check("t3_idle", 64'(cmd_valid), 64'(0));
    check("t3_stall", 64'(stall), 64'(0));
    check("t3_sb_empty", 64'(sb.size()), 64'(0));
    fin();

    // fill to DEPTH with ready low, then overflow, then drain
    cmd_ready = 1'b0;
    set_bundle(1, 1, 0, C_RD, 2'd0, 18'h00100, 10'h001, 6'd1, 1);
    cyc();
    set_bundle(0, 0, 1, C_WR, 2'd1, 18'h00201, 10'h002, 6'd2, 1);
    cyc();
    set_bundle(0, 1, 1, C_RD, 2'd2, 18'h00302, 10'h003, 6'd3, 1);
    cyc();
    set_bundle(1, 0, 0, C_RD, 2'd3, 18'h00403, 10'h004, 6'd4, 1);
    half();
    check("t4_stall_before_4th", 64'(stall), 64'(0));
    fin();
    clr_bundle();
    half();
    check("t4_stall_full", 64'(stall), 64'(1));
    check("t4_no_ovf_yet", 64'(overflow_err), 64'(0));
    fin();
    set_bundle(1, 1, 1, C_WR, 2'd1, 18'h3FFFF, 10'h3AA, 6'h15, 0);
    cyc();
    clr_bundle();
    half();
    check("t4_ovf", 64'(overflow_err), 64'(1));
    check("t4_still_full", 64'(stall), 64'(1));
    fin();
    cmd_ready = 1'b1;
    half();
    check("t4_stall_c0", 64'(stall), 64'(1));
    fin();
    half();
    check("t4_stall_c1", 64'(stall), 64'(1));
    fin();
    half();
    check("t4_stall_freed", 64'(stall), 64'(0));
    fin();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    check("t4_drained", 64'(sb.size()), 64'(0));
    half();
    check("t4_idle", 64'(cmd_valid), 64'(0));
    check("t4_ovf_sticky", 64'(overflow_err), 64'(1));
    fin();

    // backpressure with a hold_issue pulse
    cmd_ready = 1'b0;
    set_bundle(0, 1, 0, C_RD, 2'd1, 18'h01234, 10'h055, 6'h2A, 1);
    e = mk(2'd1, C_ACT, 2'd1, 18'h01234, 10'h055, 6'h2A);
    cyc();
    clr_bundle();
    for (int c = 1; c <= 5; c++) begin
      hold_issue = (c == 3);
      half();
      check("t5_valid", 64'(cmd_valid), 64'(c != 3));
      check("t5_fields", 64'(obs_cur()), 64'(e));
      fin();
    end
    hold_issue = 1'b0;
    cmd_ready = 1'b1;
    half();
    check("t5_resume", 64'(cmd_valid), 64'(1));
    fin();
    half();
    check("t5_once", 64'(cmd_valid), 64'(0));
    check("t5_sb_empty", 64'(sb.size()), 64'(0));
    fin();

    // asynchronous reset mid-bundle
    set_bundle(1, 1, 0, C_RD, 2'd2, 18'h0ABCD, 10'h100, 6'h11, 1);
    cyc();
    clr_bundle();
    half();
    check("t6_pre", 64'(cmd_class), 64'(0));
    fin();
    cmd_ready = 1'b0;
    #2;
    check("t6_act_pending", 64'(cmd_valid), 64'(1));
    check("t6_act_class", 64'(cmd_class), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 64'(cmd_valid), 64'(0));
    check("t6_fields_zero", 64'(obs_cur()), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half();
      check("t6_no_act", 64'(cmd_valid), 64'(0));
      fin();
    end
    check("t6_stall", 64'(stall), 64'(0));
    check("t6_ovf_cleared", 64'(overflow_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
